// File: rtl/pwm_capture.sv
// PWM receiver: recovers on-time and period (minus one) of an incoming PWM
// waveform in the same encoding the dac block consumes.
module pwm_capture #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [N-1:0] t_on,
    output logic [N-1:0] period,
    output logic         valid,
    output logic         timeout,
    output logic         locked
);

    localparam logic [N:0]   LIM = (N+1)'((1 << N) + 1);
    localparam logic [N-1:0] SAT = {N{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         sync1;
    logic         pwm_s;
    logic         pwm_d;
    logic         rise;
    logic         fall;
    logic         to;
    logic [N:0]   cyc;
    logic [N:0]   cyc_m1;
    logic [N-1:0] h;
    logic [N-1:0] h_sat;
    logic [N-1:0] p_sat;
    logic         stuck_done;
    logic         rep_norm;
    logic         rep_stuck;

    assign rise   = pwm_s & ~pwm_d;
    assign fall   = ~pwm_s & pwm_d;
    assign to     = (cyc == LIM) & ~rise & ~fall;
    assign cyc_m1 = cyc - 1'b1;
    assign h_sat  = (cyc > {1'b0, SAT}) ? SAT : cyc[N-1:0];
    assign p_sat  = (cyc_m1 > {1'b0, SAT}) ? SAT : cyc_m1[N-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            pwm_s <= 1'b0;
            pwm_d <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            pwm_s <= sync1;
            pwm_d <= pwm_s;
        end
    end

    // Counter saturates so a stuck input is detected once and stays quiet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc <= '0;
        end else if (rise) begin
            cyc <= (N+1)'(1);
        end else if (cyc != LIM) begin
            cyc <= cyc + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        rep_norm  = 1'b0;
        rep_stuck = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = HIGH;
                end else if (to && !stuck_done) begin
                    rep_stuck = 1'b1;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_nxt = LOW;
                end else if (to) begin
                    rep_stuck = 1'b1;
                    state_nxt = IDLE;
                end
            end
            LOW: begin
                if (rise) begin
                    rep_norm  = 1'b1;
                    state_nxt = HIGH;
                end else if (to) begin
                    rep_stuck = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h          <= '0;
            stuck_done <= 1'b0;
        end else begin
            if (state == HIGH && fall) begin
                h <= h_sat;
            end
            if (rise) begin
                stuck_done <= 1'b0;
            end else if (rep_stuck) begin
                stuck_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_on    <= '0;
            period  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            locked  <= 1'b0;
        end else begin
            valid <= rep_norm | rep_stuck;
            if (rep_norm) begin
                t_on    <= h;
                period  <= p_sat;
                timeout <= 1'b0;
                locked  <= 1'b1;
            end else if (rep_stuck) begin
                t_on    <= pwm_s ? SAT : '0;
                period  <= SAT;
                timeout <= 1'b1;
                locked  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a dac-style PWM generator drives the input
// and reported on-time/period are compared with hand-computed values.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] t_on;
    logic [7:0] period;
    logic       valid;
    logic       timeout;
    logic       locked;

    int total = 0;
    int bad = 0;

    // generator state: mode 0 = pwm, 1 = force low, 2 = force high
    int mode = 1;
    int gk = 0;
    int cur_on = 0;
    int cur_per = 1;
    int pend_on = 0;
    int pend_per = 1;

    typedef struct {
        int         on;
        int         per;
        logic [7:0] exp_t;
        logic [7:0] exp_p;
    } vec_t;

    vec_t vecs[8];

    pwm_capture #(.N(8)) dut (
        .clk(clk),
        .reset(reset),
        .pwm_in(pwm_in),
        .t_on(t_on),
        .period(period),
        .valid(valid),
        .timeout(timeout),
        .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: outputs sampled at negedge, then the next input level driven.
    task automatic tick();
        @(negedge clk);
        if (gk >= cur_per + 1) gk = 0;
        if (gk == 0) begin
            cur_on  = pend_on;
            cur_per = pend_per;
        end
        case (mode)
            0:       pwm_in = (gk < cur_on);
            1:       pwm_in = 1'b0;
            default: pwm_in = 1'b1;
        endcase
        gk++;
    endtask

    task automatic wait_valid(input int limit, output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        while (n < limit && !ok) begin
            tick();
            n++;
            if (valid) ok = 1'b1;
        end
    endtask

    task automatic expect_valid(input string name, input int limit, output int n);
        bit ok;
        wait_valid(limit, n, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: no valid within %0d cycles", name, limit);
        end
    endtask

    initial begin
        int  n;
        bit  ok;
        vecs[0] = '{64, 199, 8'd64, 8'd199};
        vecs[1] = '{100, 199, 8'd100, 8'd199};
        vecs[2] = '{1, 1, 8'd1, 8'd1};
        vecs[3] = '{255, 255, 8'd255, 8'd255};
        vecs[4] = '{1, 255, 8'd1, 8'd255};
        vecs[5] = '{256, 256, 8'd255, 8'd255};
        vecs[6] = '{3, 9, 8'd3, 8'd9};
        vecs[7] = '{64, 199, 8'd64, 8'd199};

        // reset state
        repeat (3) tick();
        check("rst_valid", int'(valid), 0);
        check("rst_t_on", int'(t_on), 0);
        check("rst_period", int'(period), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_locked", int'(locked), 0);

        // input held low from reset: one stuck-low report at cyc==257
        tick();
        reset = 1'b1;
        expect_valid("stuck_low", 600, n);
        check("stuck_low_lat", n, 258);
        check("stuck_low_t_on", int'(t_on), 0);
        check("stuck_low_period", int'(period), 255);
        check("stuck_low_timeout", int'(timeout), 1);
        check("stuck_low_locked", int'(locked), 0);
        wait_valid(600, n, ok);
        check("stuck_low_repeat", int'(ok), 0);

        // table of steady waveforms; includes the mid-stream 64 -> 100 change
        mode = 0;
        for (int i = 0; i < 8; i++) begin
            pend_on  = vecs[i].on;
            pend_per = vecs[i].per;
            expect_valid($sformatf("v%0d_settle0", i), 800, n);
            expect_valid($sformatf("v%0d_settle1", i), 800, n);
            expect_valid($sformatf("v%0d_rep0", i), 800, n);
            check($sformatf("v%0d_t_on", i), int'(t_on), int'(vecs[i].exp_t));
            check($sformatf("v%0d_period", i), int'(period), int'(vecs[i].exp_p));
            check($sformatf("v%0d_timeout", i), int'(timeout), 0);
            check($sformatf("v%0d_locked", i), int'(locked), 1);
            expect_valid($sformatf("v%0d_rep1", i), 800, n);
            check($sformatf("v%0d_spacing", i), n, vecs[i].per + 1);
            check($sformatf("v%0d_t_on2", i), int'(t_on), int'(vecs[i].exp_t));
        end

        // locked at 64/199, then input forced high
        mode = 2;
        expect_valid("stuck_high", 600, n);
        check("stuck_high_t_on", int'(t_on), 255);
        check("stuck_high_period", int'(period), 255);
        check("stuck_high_timeout", int'(timeout), 1);
        check("stuck_high_locked", int'(locked), 0);
        wait_valid(600, n, ok);
        check("stuck_high_repeat", int'(ok), 0);

        // reset pulsed while measuring a high phase
        mode = 0;
        expect_valid("relock", 800, n);
        while (gk != 30) tick();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_t_on", int'(t_on), 0);
        check("mid_rst_period", int'(period), 0);
        check("mid_rst_locked", int'(locked), 0);
        repeat (3) tick();
        gk = 0;
        tick();
        reset = 1'b1;
        expect_valid("post_rst", 800, n);
        check("post_rst_lat", n, 203);
        check("post_rst_t_on", int'(t_on), 64);
        check("post_rst_period", int'(period), 199);
        check("post_rst_timeout", int'(timeout), 0);
        check("post_rst_locked", int'(locked), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
